// File: rtl/lam_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lam_unit
//  Purpose  : Load/store access unit. Accepts a memory operation from the
//             decoder, runs one request/acknowledge transaction on the
//             word-wide data-memory port, and for loads aligns/extends the
//             returned data and writes it back to the register file.
//  Ports    : clk, rst_n               - clock, async active-low reset
//             lam_control[8:0]         - {is_store, funct3, reg}
//             lam_new                  - load issued this cycle
//             alu_out, store_data      - effective address, store value
//             busy                     - stall request to the core
//             mem_req/we/addr/be/wdata - memory request (registered)
//             mem_rdata, mem_ack       - memory response
//             wb_en/wb_sel/wb_data     - register write-back (registered)
//             lam_fault                - one-cycle misalign/illegal pulse
//  Revision : 1.0 - initial release
// ============================================================================
module lam_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8:0]        lam_control,
  input  logic              lam_new,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_en,
  output logic [4:0]        wb_sel,
  output logic [31:0]       wb_data,
  output logic              lam_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WB    = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // Decoded view of the incoming operation
  logic       w_is_store;
  logic [2:0] w_funct3;
  logic [4:0] w_reg;
  logic       w_accept;
  logic       w_legal;
  logic       w_misaligned;
  logic       w_fault;
  logic [3:0] w_be;
  logic [31:0] w_wdata;

  // Operation context kept for the response phase
  logic       r_is_store;
  logic [2:0] r_funct3;
  logic [4:0] r_reg;
  logic [1:0] r_offset;

  // Load alignment
  logic [7:0]  w_byte_lane;
  logic [15:0] w_half_lane;
  logic [31:0] w_load_data;

  assign w_is_store = lam_control[8];
  assign w_funct3   = lam_control[7:5];
  assign w_reg      = lam_control[4:0];

  assign w_accept = (state == S_IDLE) && (lam_new || w_is_store);

  // Stall in the issue cycle itself, hence the combinational accept term
  assign busy = (state != S_IDLE) || w_accept;

  always_comb begin
    w_legal = 1'b0;
    if (w_is_store) begin
      w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
    end else begin
      case (w_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word
  always_comb begin
    w_misaligned = 1'b0;
    case (w_funct3[1:0])
      2'b01:   w_misaligned = alu_out[0];
      2'b10:   w_misaligned = (alu_out[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_fault = !w_legal || w_misaligned;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (w_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_out[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = alu_out[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    w_byte_lane = mem_rdata[7:0];
    case (r_offset)
      2'd0:    w_byte_lane = mem_rdata[7:0];
      2'd1:    w_byte_lane = mem_rdata[15:8];
      2'd2:    w_byte_lane = mem_rdata[23:16];
      default: w_byte_lane = mem_rdata[31:24];
    endcase
  end

  assign w_half_lane = r_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = mem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte_lane[7]}}, w_byte_lane};
      3'b001:  w_load_data = {{16{w_half_lane[15]}}, w_half_lane};
      3'b100:  w_load_data = {24'h0, w_byte_lane};
      3'b101:  w_load_data = {16'h0, w_half_lane};
      default: w_load_data = mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (w_accept) begin
          state_nx = w_fault ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_nx = r_is_store ? S_IDLE : S_WB;
        end
      end
      S_WB:    state_nx = S_IDLE;
      S_FAULT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operation context
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_reg      <= 5'd0;
      r_offset   <= 2'd0;
    end else if (w_accept) begin
      r_is_store <= w_is_store;
      r_funct3   <= w_funct3;
      r_reg      <= w_reg;
      r_offset   <= alu_out[1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Memory port: loaded once at accept and frozen until the acknowledge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
    end else if (w_accept && !w_fault) begin
      mem_req   <= 1'b1;
      mem_we    <= w_is_store;
      mem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
      mem_be    <= w_be;
      mem_wdata <= w_is_store ? w_wdata : 32'h0;
    end else if ((state == S_REQ) && mem_ack) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Write-back and fault reporting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en     <= 1'b0;
      wb_sel    <= 5'd0;
      wb_data   <= 32'h0;
      lam_fault <= 1'b0;
    end else begin
      // Writes to x0 still perform the read but never strobe the register file
      wb_en     <= (state == S_REQ) && mem_ack && !r_is_store && (r_reg != 5'd0);
      lam_fault <= w_accept && w_fault;
      if ((state == S_REQ) && mem_ack && !r_is_store) begin
        wb_sel  <= r_reg;
        wb_data <= w_load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lam_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lam_unit
//  Purpose  : Scoreboard bench for lam_unit. Stimulus pushes expected memory
//             requests, write-backs and faults into queues; a monitor pops
//             and compares whenever the DUT presents one of them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lam_unit;

  logic        clk;
  logic        rst_n;
  logic [8:0]  lam_control;
  logic        lam_new;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        lam_fault;

  lam_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lam_control(lam_control),
    .lam_new    (lam_new),
    .alu_out    (alu_out),
    .store_data (store_data),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_en      (wb_en),
    .wb_sel     (wb_sel),
    .wb_data    (wb_data),
    .lam_fault  (lam_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   fault_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic in_req = 1'b0;
  req_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_req = 1'b0;
    end else begin
      if (mem_req) begin
        if (!in_req) begin
          if (req_q.size() == 0) begin
            unexpected("mem_req");
          end else begin
            cur    = req_q.pop_front();
            in_req = 1'b1;
            check("mem_addr", mem_addr, cur.addr);
            check("mem_be", {28'h0, mem_be}, {28'h0, cur.be});
            check("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
          end
        end else begin
          check("mem_addr_hold", mem_addr, cur.addr);
          check("mem_be_hold", {28'h0, mem_be}, {28'h0, cur.be});
          check("mem_we_hold", {31'h0, mem_we}, {31'h0, cur.we});
          if (cur.we) check("mem_wdata_hold", mem_wdata, cur.wdata);
        end
      end else begin
        in_req = 1'b0;
      end
      if (wb_en) begin
        if (wb_q.size() == 0) begin
          unexpected("wb_en");
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          check("wb_sel", {27'h0, wb_sel}, {27'h0, w.sel});
          check("wb_data", wb_data, w.data);
        end
      end
      if (lam_fault) begin
        if (fault_q.size() == 0) begin
          unexpected("lam_fault");
        end else begin
          void'(fault_q.pop_front());
          checks++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: called just after a negedge; returns in the first IDLE cycle
  // after completion so the next call exercises a back-to-back accept.
  // --------------------------------------------------------------------------
  task automatic do_op(
    input string       name,
    input logic        st,
    input logic [2:0]  f3,
    input logic [4:0]  rg,
    input logic [31:0] addr,
    input logic [31:0] sdata,
    input logic [31:0] rdata,
    input int          d,
    input logic        exp_fault,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic        exp_wb,
    input logic [31:0] exp_wbd
  );
    req_t r;
    wb_t  w;
    int   exp_cyc;
    int   got;
    if (exp_fault) begin
      fault_q.push_back(1);
      exp_cyc = 2;
    end else begin
      r.addr  = {addr[31:2], 2'b00};
      r.be    = exp_be;
      r.we    = st;
      r.wdata = exp_wdata;
      req_q.push_back(r);
      exp_cyc = st ? d + 2 : d + 3;
    end
    if (exp_wb) begin
      w.sel  = rg;
      w.data = exp_wbd;
      wb_q.push_back(w);
    end
    lam_control = {st, f3, rg};
    lam_new     = !st;
    alu_out     = addr;
    store_data  = sdata;
    #1;
    check({name, "_busy_issue"}, {31'h0, busy}, 32'h1);
    got = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        lam_control = 9'h0;
        lam_new     = 1'b0;
        alu_out     = 32'h0;
        store_data  = 32'h0;
      end
      mem_ack   = !exp_fault && (i == 1 + d);
      mem_rdata = mem_ack ? rdata : 32'h5A5A_5A5A;
      #1;
      if (!busy) begin
        got = i;
        break;
      end
    end
    mem_ack = 1'b0;
    if (got < 0) begin
      unexpected({name, "_busy_timeout"});
    end else begin
      check({name, "_busy_drop"}, got, exp_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    lam_control = 9'h0;
    lam_new     = 1'b0;
    alu_out     = 32'h0;
    store_data  = 32'h0;
    mem_rdata   = 32'h0;
    mem_ack     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_wb_en", {31'h0, wb_en}, 32'h0);
    check("rst_fault", {31'h0, lam_fault}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_wb_sel", {27'h0, wb_sel}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    //     name     st    f3      rg     addr          sdata         rdata         d  flt   be       wdata         wb    wbdata
    do_op("lw",    1'b0, 3'b010, 5'd5,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF);
    do_op("lb",    1'b0, 3'b000, 5'd6,  32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80);
    do_op("lbu",   1'b0, 3'b100, 5'd7,  32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'h0000_0080);
    do_op("sh",    1'b1, 3'b001, 5'd9,  32'h0000_0202, 32'h0000_ABCD, 32'h0,       3, 1'b0, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
    do_op("lw_mis",1'b0, 3'b010, 5'd3,  32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0);
    do_op("ld_ill",1'b0, 3'b011, 5'd3,  32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0);
    do_op("lh_x0", 1'b0, 3'b001, 5'd0,  32'h0000_0010, 32'h0,        32'h0000_8001, 0, 1'b0, 4'b0011, 32'h0,        1'b0, 32'h0);
    do_op("lhu_hi",1'b0, 3'b101, 5'd10, 32'h0000_0012, 32'h0,        32'h8001_7FFF, 1, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h0000_8001);
    do_op("lh_hi", 1'b0, 3'b001, 5'd11, 32'h0000_0012, 32'h0,        32'h8001_7FFF, 2, 1'b0, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001);
    do_op("lh_lo", 1'b0, 3'b001, 5'd12, 32'h0000_0010, 32'h0,        32'h8001_7FFF, 0, 1'b0, 4'b0011, 32'h0,        1'b1, 32'h0000_7FFF);
    do_op("sb",    1'b1, 3'b000, 5'd4,  32'h0000_0201, 32'h1234_56A5, 32'h0,       0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0);
    do_op("sw",    1'b1, 3'b010, 5'd8,  32'h0000_0204, 32'hCAFE_F00D, 32'h0,       1, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);
    do_op("st_ill",1'b1, 3'b011, 5'd8,  32'h0000_0204, 32'h1111_1111, 32'h0,       0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0);
    do_op("sh_mis",1'b1, 3'b001, 5'd8,  32'h0000_0203, 32'h1111_1111, 32'h0,       0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0);

    // Reset while a load waits for its acknowledge
    begin
      req_t r;
      r.addr  = 32'h0000_0300;
      r.be    = 4'b1111;
      r.we    = 1'b0;
      r.wdata = 32'h0;
      req_q.push_back(r);
    end
    lam_control = {1'b0, 3'b010, 5'd13};
    lam_new     = 1'b1;
    alu_out     = 32'h0000_0300;
    @(negedge clk);
    lam_control = 9'h0;
    lam_new     = 1'b0;
    alu_out     = 32'h0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", {31'h0, mem_req}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_wb_en", {31'h0, wb_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("arst_idle_busy", {31'h0, busy}, 32'h0);
    do_op("lw_post",1'b0, 3'b010, 5'd14, 32'h0000_0400, 32'h0,       32'h1357_9BDF, 1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h1357_9BDF);

    repeat (3) @(negedge clk);
    check("req_q_empty", req_q.size(), 32'h0);
    check("wb_q_empty", wb_q.size(), 32'h0);
    check("fault_q_empty", fault_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
